param_fsm_suite: RTL and testbench

PARAM_FSM_SUITE -- requirements
Module: param_fsm_suite

---
 rtl/param_fsm_suite.sv | 158 +++++++++++++++
 tb/tb_param_fsm_suite.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_fsm_suite.sv
// Brightness stepper, serial pattern detector and LED sequencer.
// Define FSM_CLICK_EDGE_EN to make click/dim act on rising edges only.
module param_fsm_suite #(
  parameter int LEVELS = 3,
  parameter int PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PATTERN = 3'b011,
  parameter int LED_N = 4,
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic click,
  input  logic dim,
  input  logic bit_in,
  input  logic bit_valid,
  input  logic led_en,
  input  logic led_mode,
  output logic [$clog2(LEVELS)-1:0] light_out,
  output logic light_max,
  output logic detect,
  output logic [7:0] det_count,
  output logic [LED_N-1:0] leds
);

  localparam int LW = $clog2(LEVELS);
  localparam int FW = $clog2(PAT_LEN + 1);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [LW-1:0] LTOP = LW'(LEVELS - 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);
  localparam logic [PW-1:0] PTOP = PW'(DIV - 1);
  localparam logic [LED_N-1:0] LED_RST =
    {1'b1, {(LED_N-1){1'b0}}};

  typedef enum logic {
    TO_LSB = 1'b0,
    TO_MSB = 1'b1
  } dir_e;

  logic [LW-1:0] light_q, light_d;
  logic up, dn;

`ifdef FSM_CLICK_EDGE_EN
  logic click_q, dim_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      click_q <= 1'b0;
      dim_q   <= 1'b0;
    end else begin
      click_q <= click;
      dim_q   <= dim;
    end
  end

  assign up = click & ~click_q;
  assign dn = dim & ~dim_q;
`else
  assign up = click;
  assign dn = dim;
`endif

  always_comb begin
    light_d = light_q;
    unique case (1'b1)
      up && !dn:
        light_d = (light_q == LTOP) ? '0
                : light_q + 1'b1;
      dn && !up:
        light_d = (light_q == '0) ? light_q
                : light_q - 1'b1;
      default: ;
    endcase
  end

  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d;
  logic det_q, det_d;
  logic [7:0] cnt_q, cnt_d;

  // A match needs a full window of valid bits, including this one.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    det_d  = 1'b0;
    if (bit_valid) begin
      hist_d = {hist_q[PAT_LEN-2:0], bit_in};
      fill_d = (fill_q == FULL) ? fill_q
             : fill_q + 1'b1;
      det_d  = (fill_d == FULL) &&
               (hist_d == PATTERN);
    end
    cnt_d = (det_d && cnt_q != 8'hFF)
          ? cnt_q + 1'b1 : cnt_q;
  end

  logic [PW-1:0] pre_q, pre_d;
  logic [LED_N-1:0] leds_q, leds_d;
  dir_e dir_q, dir_d;
  logic tick;

  assign tick = led_en && (pre_q == PTOP);

  always_comb begin
    pre_d  = pre_q;
    leds_d = leds_q;
    dir_d  = dir_q;
    if (led_en) pre_d = tick ? '0 : pre_q + 1'b1;
    if (!led_mode) dir_d = TO_LSB;
    if (tick) begin
      if (!led_mode) begin
        leds_d = {leds_q[0], leds_q[LED_N-1:1]};
      end else if (dir_q == TO_LSB) begin
        if (leds_q[0]) begin
          leds_d = leds_q << 1;
          dir_d  = TO_MSB;
        end else begin
          leds_d = leds_q >> 1;
        end
      end else begin
        if (leds_q[LED_N-1]) begin
          leds_d = leds_q >> 1;
          dir_d  = TO_LSB;
        end else begin
          leds_d = leds_q << 1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      light_q <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      det_q   <= 1'b0;
      cnt_q   <= '0;
      pre_q   <= '0;
      leds_q  <= LED_RST;
      dir_q   <= TO_LSB;
    end else begin
      light_q <= light_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      det_q   <= det_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      leds_q  <= leds_d;
      dir_q   <= dir_d;
    end
  end

  assign light_out = light_q;
  assign light_max = (light_q == LTOP);
  assign detect    = det_q;
  assign det_count = cnt_q;
  assign leds      = leds_q;

endmodule

// File: tb/tb_param_fsm_suite.sv
// Directed bench for param_fsm_suite (LEVELS=3, PATTERN=011,
// LED_N=4, DIV=2); works with or without FSM_CLICK_EDGE_EN.
module tb_param_fsm_suite;

  logic clk = 1'b0;
  logic rst, click, dim, bit_in, bit_valid;
  logic led_en, led_mode;
  logic [1:0] light_out;
  logic light_max, detect;
  logic [7:0] det_count;
  logic [3:0] leds;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  param_fsm_suite #(
    .LEVELS(3), .PAT_LEN(3), .PATTERN(3'b011),
    .LED_N(4), .DIV(2)
  ) dut (
    .clk(clk), .rst(rst), .click(click), .dim(dim),
    .bit_in(bit_in), .bit_valid(bit_valid),
    .led_en(led_en), .led_mode(led_mode),
    .light_out(light_out), .light_max(light_max),
    .detect(detect), .det_count(det_count),
    .leds(leds)
  );

  typedef struct {
    logic click, dim, bit_in, bit_valid, led_mode;
    logic [1:0] light;
    logic max, det;
    logic [3:0] leds;
  } vec_t;

  vec_t tv[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm,
                       logic [31:0] act,
                       logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    click = 0; dim = 0; bit_in = 0;
    bit_valid = 0; led_en = 0; led_mode = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  logic [3:0] pp[8];
  logic [3:0] rot[6];
  logic [1:0] wl[4];
  logic wm[4];
  logic [1:0] sb[5];
  logic sd[5];

  initial begin
    tv[0]  = '{1,0,0,1,0, 2'd1,0,0,4'b1000};
    tv[1]  = '{0,0,1,1,1, 2'd1,0,0,4'b1000};
    tv[2]  = '{1,0,1,1,0, 2'd2,1,1,4'b1000};
    tv[3]  = '{0,0,1,1,1, 2'd2,1,0,4'b1000};
    tv[4]  = '{1,0,0,1,0, 2'd0,0,0,4'b1000};
    tv[5]  = '{0,1,1,1,1, 2'd0,0,0,4'b1000};
    tv[6]  = '{0,0,0,0,0, 2'd0,0,0,4'b1000};
    tv[7]  = '{1,1,1,1,1, 2'd0,0,1,4'b1000};
    tv[8]  = '{0,1,0,0,0, 2'd0,0,0,4'b1000};
    tv[9]  = '{1,0,0,0,1, 2'd1,0,0,4'b1000};
    tv[10] = '{0,1,0,0,0, 2'd0,0,0,4'b1000};
    pp = '{4'b1000, 4'b0100, 4'b0010, 4'b0001,
           4'b0010, 4'b0100, 4'b1000, 4'b0100};
    rot = '{4'b0001, 4'b0001, 4'b1000,
            4'b1000, 4'b0100, 4'b0100};
    wl = '{2'd1, 2'd2, 2'd0, 2'd1};
    wm = '{1'b0, 1'b1, 1'b0, 1'b0};
    sb = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b11};
    sd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    idle_inputs();
    rst = 1;
    step();
    step();
    check("rst light", light_out, 0);
    check("rst max", light_max, 0);
    check("rst detect", detect, 0);
    check("rst count", det_count, 0);
    check("rst leds", leds, 4'b1000);
    rst = 0;

    for (int i = 0; i < 11; i++) begin
      click     = tv[i].click;
      dim       = tv[i].dim;
      bit_in    = tv[i].bit_in;
      bit_valid = tv[i].bit_valid;
      led_mode  = tv[i].led_mode;
      step();
      check($sformatf("row%0d light", i),
            light_out, tv[i].light);
      check($sformatf("row%0d max", i),
            light_max, tv[i].max);
      check($sformatf("row%0d detect", i),
            detect, tv[i].det);
      check($sformatf("row%0d leds", i),
            leds, tv[i].leds);
    end
    check("table count", det_count, 2);

    idle_inputs();
    bit_valid = 1;
    bit_in = 0; step();
    bit_in = 1; step();
    bit_valid = 0; click = 1; step();
    check("pre-rst light", light_out, 1);
    click = 0; led_en = 1;
    step(); step(); step();
    check("pre-rst leds", leds, 4'b0100);
    rst = 1; click = 1; bit_in = 1;
    bit_valid = 1; led_mode = 1;
    step();
    check("mid-rst light", light_out, 0);
    check("mid-rst leds", leds, 4'b1000);
    check("mid-rst detect", detect, 0);
    check("mid-rst count", det_count, 0);
    rst = 0; click = 0; led_en = 0;
    step();
    check("post-rst bit1 det", detect, 0);
    step();
    check("post-rst bit2 det", detect, 0);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      bit_in = sb[i][1];
      bit_valid = sb[i][0];
      step();
      check($sformatf("gap%0d detect", i),
            detect, sd[i]);
    end
    bit_valid = 0;
    step();
    check("gap pulse width", detect, 0);
    check("gap count", det_count, 1);

    do_reset();
    bit_valid = 1;
    bit_in = 0; step();
    bit_in = 1; step();
    bit_valid = 0; step();
    check("invalid finish det", detect, 0);
    step();
    check("invalid finish det2", detect, 0);
    check("invalid finish cnt", det_count, 0);

    do_reset();
    led_mode = 1; led_en = 1;
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("pp%0d leds", k),
            leds, pp[k/2]);
      check($sformatf("pp%0d onehot", k),
            32'($onehot(leds)), 1);
    end
    led_en = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("freeze%0d leds", k),
            leds, 4'b0010);
    end
    led_mode = 0; led_en = 1;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("rot%0d leds", k),
            leds, rot[k]);
    end
    led_mode = 1;
    step();
    check("mode back leds", leds, 4'b0010);

`ifndef FSM_CLICK_EDGE_EN
    do_reset();
    click = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("wrap%0d light", k),
            light_out, wl[k]);
      check($sformatf("wrap%0d max", k),
            light_max, wm[k]);
    end
`else
    do_reset();
    click = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("held%0d light", k),
            light_out, 1);
    end
    click = 0; step();
    click = 1; dim = 1; step();
    check("edge both light", light_out, 1);
    click = 0; dim = 0; step();
    dim = 1; step();
    check("edge dim light", light_out, 0);
    step();
    check("edge dim held", light_out, 0);
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
